// File: rtl/axi_burst_bridge_if.sv
// AXI4 read/write channel bundle between the burst bridge (master) and the DRAM slave.
interface axi_burst_bridge_if #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned AXI_ADDR_W = 17
);
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [AXI_ADDR_W-1:0] AR_ADDR;
  logic [7:0]            AR_LEN;

  logic                  R_VALID;
  logic                  R_READY;
  logic [DATA_W-1:0]     R_DATA;
  logic [1:0]            R_RESP;
  logic                  R_LAST;

  logic                  AW_VALID;
  logic                  AW_READY;
  logic [AXI_ADDR_W-1:0] AW_ADDR;
  logic [7:0]            AW_LEN;

  logic                  W_VALID;
  logic                  W_READY;
  logic [DATA_W-1:0]     W_DATA;
  logic                  W_LAST;

  logic                  B_VALID;
  logic                  B_READY;
  logic [1:0]            B_RESP;

  modport master (
    output AR_VALID, AR_ADDR, AR_LEN,
    input  AR_READY,
    input  R_VALID, R_DATA, R_RESP, R_LAST,
    output R_READY,
    output AW_VALID, AW_ADDR, AW_LEN,
    input  AW_READY,
    output W_VALID, W_DATA, W_LAST,
    input  W_READY,
    input  B_VALID, B_RESP,
    output B_READY
  );

  modport slave (
    input  AR_VALID, AR_ADDR, AR_LEN,
    output AR_READY,
    output R_VALID, R_DATA, R_RESP, R_LAST,
    input  R_READY,
    input  AW_VALID, AW_ADDR, AW_LEN,
    output AW_READY,
    input  W_VALID, W_DATA, W_LAST,
    output W_READY,
    output B_VALID, B_RESP,
    input  B_READY
  );
endinterface

// File: rtl/axi_burst_bridge.sv
// Client-to-AXI4 burst bridge: one read or write INCR burst at a time toward DRAM.
// Optional watchdog enabled by defining AXI_BRIDGE_TIMEOUT_EN.
module axi_burst_bridge #(
  parameter int unsigned                  DATA_W      = 64,
  parameter int unsigned                  ADDR_W      = 8,
  parameter int unsigned                  AXI_ADDR_W  = 17,
  parameter logic [AXI_ADDR_W-1:0]        BASE_ADDR   = 17'h10000,
  parameter int unsigned                  BYTE_SHIFT  = 3,
  parameter int unsigned                  LEN_W       = 4,
  parameter int unsigned                  TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              C_in_valid,
  input  logic              C_r_wb,
  input  logic [ADDR_W-1:0] C_addr,
  input  logic [LEN_W-1:0]  C_len,
  input  logic [DATA_W-1:0] C_wdata,
  input  logic              C_wvalid,
  output logic              C_wready,
  output logic [DATA_W-1:0] C_rdata,
  output logic              C_rvalid,
  output logic              C_busy,
  output logic              C_out_valid,
  output logic              C_err,
  axi_burst_bridge_if.master axi
);
  localparam int unsigned CntW = LEN_W + 1;

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrAddr, StWrData, StWrResp, StDone
  } state_e;

  state_e                r_state, w_state_next;
  logic [AXI_ADDR_W-1:0] r_addr, w_addr_next;
  logic [LEN_W-1:0]      r_len, w_len_next;
  logic [CntW-1:0]       r_cnt, w_cnt_next;
  logic                  r_err, w_err_next;
  logic [DATA_W-1:0]     r_buf, w_buf_next;
  logic                  r_buf_full, w_buf_full_next;
  logic [DATA_W-1:0]     r_rdata, w_rdata_next;
  logic                  r_rvalid, w_rvalid_next;
  logic [AXI_ADDR_W-1:0] w_req_addr;
  logic                  w_last_beat;
  logic                  w_timeout;

  assign w_req_addr  = BASE_ADDR + (AXI_ADDR_W'(C_addr) << BYTE_SHIFT);
  // Beat counter decides the end of a burst; R_LAST is never consulted.
  assign w_last_beat = (r_cnt == {1'b0, r_len});

  assign C_busy   = (r_state != StIdle);
  assign C_rvalid = r_rvalid;
  assign C_rdata  = r_rdata;

`ifdef AXI_BRIDGE_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYC + 1);

  logic [WdogW-1:0] r_wdog;
  logic             w_any_hs;
  logic             w_wdog_active;
  logic             w_unused_r_last;

  assign w_unused_r_last = axi.R_LAST;
  assign w_any_hs = (axi.AR_VALID && axi.AR_READY) || (axi.R_VALID && axi.R_READY) ||
                    (axi.AW_VALID && axi.AW_READY) || (axi.W_VALID && axi.W_READY) ||
                    (axi.B_VALID && axi.B_READY);
  assign w_wdog_active = (r_state != StIdle) && (r_state != StDone);
  assign w_timeout     = w_wdog_active && (r_wdog == WdogW'(TIMEOUT_CYC));

  // Watchdog: counts stalled cycles, cleared by any AXI handshake or outside active states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (!w_wdog_active || w_any_hs || w_timeout) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WdogW'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = axi.R_LAST ^ (TIMEOUT_CYC == 0);
  assign w_timeout    = 1'b0;
`endif

  // Next-state, datapath updates and all bus outputs.
  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_len_next      = r_len;
    w_cnt_next      = r_cnt;
    w_err_next      = r_err;
    w_buf_next      = r_buf;
    w_buf_full_next = r_buf_full;
    w_rvalid_next   = 1'b0;
    w_rdata_next    = '0;
    axi.AR_VALID    = 1'b0;
    axi.AR_ADDR     = '0;
    axi.AR_LEN      = '0;
    axi.R_READY     = 1'b0;
    axi.AW_VALID    = 1'b0;
    axi.AW_ADDR     = '0;
    axi.AW_LEN      = '0;
    axi.W_VALID     = 1'b0;
    axi.W_DATA      = '0;
    axi.W_LAST      = 1'b0;
    axi.B_READY     = 1'b0;
    C_wready        = 1'b0;
    C_out_valid     = 1'b0;
    C_err           = 1'b0;

    if (w_timeout) begin
      // All VALID/READY stay low this cycle; finish with an error.
      w_state_next = StDone;
      w_err_next   = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (C_in_valid) begin
            w_addr_next     = w_req_addr;
            w_len_next      = C_len;
            w_cnt_next      = '0;
            w_err_next      = 1'b0;
            w_buf_next      = '0;
            w_buf_full_next = 1'b0;
            w_state_next    = C_r_wb ? StRdAddr : StWrAddr;
          end
        end
        StRdAddr: begin
          axi.AR_VALID = 1'b1;
          axi.AR_ADDR  = r_addr;
          axi.AR_LEN   = 8'(r_len);
          if (axi.AR_READY) w_state_next = StRdData;
        end
        StRdData: begin
          axi.R_READY = 1'b1;
          if (axi.R_VALID) begin
            w_rvalid_next = 1'b1;
            w_rdata_next  = axi.R_DATA;
            w_cnt_next    = r_cnt + CntW'(1);
            if (axi.R_RESP != 2'b00) w_err_next = 1'b1;
            if (w_last_beat) w_state_next = StDone;
          end
        end
        StWrAddr: begin
          axi.AW_VALID = 1'b1;
          axi.AW_ADDR  = r_addr;
          axi.AW_LEN   = 8'(r_len);
          C_wready     = !r_buf_full;
          if (axi.AW_READY) w_state_next = StWrData;
        end
        StWrData: begin
          C_wready    = !r_buf_full;
          axi.W_VALID = r_buf_full;
          axi.W_DATA  = r_buf_full ? r_buf : '0;
          axi.W_LAST  = r_buf_full && w_last_beat;
          if (r_buf_full && axi.W_READY) begin
            w_buf_full_next = 1'b0;
            w_buf_next      = '0;
            w_cnt_next      = r_cnt + CntW'(1);
            if (w_last_beat) w_state_next = StWrResp;
          end
        end
        StWrResp: begin
          axi.B_READY = 1'b1;
          if (axi.B_VALID) begin
            if (axi.B_RESP != 2'b00) w_err_next = 1'b1;
            w_state_next = StDone;
          end
        end
        StDone: begin
          C_out_valid  = 1'b1;
          C_err        = r_err;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase

      // Single-entry client write buffer; only loads while empty, so never collides with a drain.
      if (C_wready && C_wvalid) begin
        w_buf_next      = C_wdata;
        w_buf_full_next = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_len      <= w_len_next;
      r_cnt      <= w_cnt_next;
      r_err      <= w_err_next;
      r_buf      <= w_buf_next;
      r_buf_full <= w_buf_full_next;
      r_rdata    <= w_rdata_next;
      r_rvalid   <= w_rvalid_next;
    end
  end
endmodule

// File: tb/tb_axi_burst_bridge.sv
// Directed, table-driven bench for axi_burst_bridge with a cycle-stepped AXI slave model.
`timescale 1ns/1ps
module tb_axi_burst_bridge;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned AXI_ADDR_W = 17;
  localparam int unsigned LEN_W      = 4;
  localparam logic [63:0] RD_BASE    = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] WR_BASE    = 64'hCAFE_0000_0000_000A;

  typedef struct {
    bit                    r_wb;
    logic [ADDR_W-1:0]     addr;
    logic [LEN_W-1:0]      len;
    int                    ar_delay;
    bit                    gaps;
    bit                    no_last;
    int                    r_err_beat;
    logic [1:0]            b_resp;
    bit                    w_toggle;
    logic [AXI_ADDR_W-1:0] exp_addr;
    bit                    exp_err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              C_in_valid, C_r_wb, C_wvalid;
  logic [ADDR_W-1:0] C_addr;
  logic [LEN_W-1:0]  C_len;
  logic [DATA_W-1:0] C_wdata;
  logic              C_wready, C_rvalid, C_busy, C_out_valid, C_err;
  logic [DATA_W-1:0] C_rdata;

  axi_burst_bridge_if #(.DATA_W(DATA_W), .AXI_ADDR_W(AXI_ADDR_W)) bus ();

  axi_burst_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AXI_ADDR_W(AXI_ADDR_W), .BASE_ADDR(17'h10000),
    .BYTE_SHIFT(3), .LEN_W(LEN_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
    .C_len(C_len), .C_wdata(C_wdata), .C_wvalid(C_wvalid), .C_wready(C_wready),
    .C_rdata(C_rdata), .C_rvalid(C_rvalid), .C_busy(C_busy), .C_out_valid(C_out_valid),
    .C_err(C_err), .axi(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  vec_t tbl[7];
  vec_t cfg;
  int ar_wait, r_left, r_idx, wr_idx, wr_n, ar_hs, aw_hs, done_cnt, rdata_nz, arv_cycles;
  bit r_hs, b_hs, b_pend, r_phase, w_phase;
  logic done_err;
  logic [AXI_ADDR_W-1:0] ar_addr_seen, aw_addr_seen;
  logic [7:0] ar_len_seen, aw_len_seen;
  logic [63:0] rd_q[$];
  logic [63:0] w_q[$];
  logic wl_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_state();
    ar_wait = 0; r_left = 0; r_idx = 0; wr_idx = 0; wr_n = 0; ar_hs = 0; aw_hs = 0;
    done_cnt = 0; arv_cycles = 0; r_hs = 0; b_hs = 0; b_pend = 0; r_phase = 0; w_phase = 0;
    done_err = 0; ar_addr_seen = '0; aw_addr_seen = '0; ar_len_seen = '0; aw_len_seen = '0;
    rd_q.delete(); w_q.delete(); wl_q.delete();
    C_in_valid = 0; C_r_wb = 0; C_addr = '0; C_len = '0; C_wdata = '0; C_wvalid = 0;
    bus.AR_READY = 0; bus.R_VALID = 0; bus.R_DATA = '0; bus.R_RESP = '0; bus.R_LAST = 0;
    bus.AW_READY = 0; bus.W_READY = 0; bus.B_VALID = 0; bus.B_RESP = '0;
  endtask

  // Drive inputs for the coming rising edge, note handshakes, then sample at the falling edge.
  task automatic tick();
    if (wr_idx < wr_n) begin
      C_wvalid = 1; C_wdata = WR_BASE + 64'(wr_idx);
    end else begin
      C_wvalid = 0; C_wdata = '0;
    end
    bus.AR_READY = bus.AR_VALID && (ar_wait >= cfg.ar_delay);
    if (bus.AR_VALID && !bus.AR_READY) ar_wait++;
    bus.AW_READY = bus.AW_VALID;
    if (r_hs) begin
      bus.R_VALID = 0; bus.R_DATA = '0; bus.R_RESP = '0; bus.R_LAST = 0; r_hs = 0;
    end
    if (!bus.R_VALID && r_left > 0 && (!cfg.gaps || r_phase)) begin
      bus.R_VALID = 1;
      bus.R_DATA  = RD_BASE + 64'(r_idx);
      bus.R_RESP  = (r_idx == cfg.r_err_beat) ? 2'b10 : 2'b00;
      bus.R_LAST  = (r_left == 1) && !cfg.no_last;
    end
    r_phase = !r_phase;
    bus.W_READY = cfg.w_toggle ? w_phase : 1'b1;
    w_phase = !w_phase;
    if (b_hs) begin
      bus.B_VALID = 0; bus.B_RESP = '0; b_hs = 0;
    end
    if (b_pend) begin
      bus.B_VALID = 1; bus.B_RESP = cfg.b_resp; b_pend = 0;
    end
    if (C_wvalid && C_wready) wr_idx++;
    if (bus.AR_VALID && bus.AR_READY) begin
      ar_hs++; ar_addr_seen = bus.AR_ADDR; ar_len_seen = bus.AR_LEN;
      r_left = int'(bus.AR_LEN) + 1; r_idx = 0; ar_wait = 0;
    end
    if (bus.AW_VALID && bus.AW_READY) begin
      aw_hs++; aw_addr_seen = bus.AW_ADDR; aw_len_seen = bus.AW_LEN;
    end
    if (bus.R_VALID && bus.R_READY) begin
      r_left--; r_idx++; r_hs = 1;
    end
    if (bus.W_VALID && bus.W_READY) begin
      w_q.push_back(bus.W_DATA); wl_q.push_back(bus.W_LAST);
      if (w_q.size() == int'(aw_len_seen) + 1) b_pend = 1;
    end
    if (bus.B_VALID && bus.B_READY) b_hs = 1;
    @(negedge clk);
    if (C_rvalid) rd_q.push_back(C_rdata);
    else if (C_rdata != '0) rdata_nz++;
    if (C_out_valid) begin
      done_cnt++; done_err = C_err;
    end
    if (bus.AR_VALID) arv_cycles++;
  endtask

  task automatic start_req(input vec_t v);
    clear_state();
    cfg = v;
    wr_n = v.r_wb ? 0 : int'(v.len) + 1;
    C_r_wb = v.r_wb; C_addr = v.addr; C_len = v.len; C_in_valid = 1;
    tick();
    C_in_valid = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    start_req(v);
    chk({tag, "_busy"}, 64'(C_busy), 64'd1);
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick(); n++;
    end
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err"}, 64'(done_err), 64'(v.exp_err));
    tick();
    chk({tag, "_idle_after"}, 64'(C_busy), 64'd0);
    chk({tag, "_one_pulse"}, 64'(done_cnt), 64'd1);
    if (v.r_wb) begin
      chk({tag, "_ar_hs"}, 64'(ar_hs), 64'd1);
      chk({tag, "_ar_addr"}, 64'(ar_addr_seen), 64'(v.exp_addr));
      chk({tag, "_ar_len"}, 64'(ar_len_seen), 64'(v.len));
      chk({tag, "_beats"}, 64'(rd_q.size()), 64'(v.len) + 64'd1);
      for (int i = 0; i < rd_q.size(); i++)
        chk($sformatf("%s_rdata%0d", tag, i), rd_q[i], RD_BASE + 64'(i));
    end else begin
      chk({tag, "_aw_hs"}, 64'(aw_hs), 64'd1);
      chk({tag, "_aw_addr"}, 64'(aw_addr_seen), 64'(v.exp_addr));
      chk({tag, "_aw_len"}, 64'(aw_len_seen), 64'(v.len));
      chk({tag, "_beats"}, 64'(w_q.size()), 64'(v.len) + 64'd1);
      for (int i = 0; i < w_q.size(); i++) begin
        chk($sformatf("%s_wdata%0d", tag, i), w_q[i], WR_BASE + 64'(i));
        chk($sformatf("%s_wlast%0d", tag, i), 64'(wl_q[i]), 64'(i == int'(v.len)));
      end
    end
  endtask

  initial begin
    vec_t v;
    int n;
    // r_wb, addr, len, ar_delay, gaps, no_last, r_err_beat, b_resp, w_toggle, exp_addr, exp_err
    tbl[0] = '{1'b1, 8'h05, 4'd0,  1, 1'b0, 1'b0, -1, 2'b00, 1'b0, 17'h10028, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 4'd3,  0, 1'b1, 1'b1, -1, 2'b00, 1'b0, 17'h107F8, 1'b0};
    tbl[2] = '{1'b0, 8'h10, 4'd2,  0, 1'b0, 1'b0, -1, 2'b00, 1'b1, 17'h10080, 1'b0};
    tbl[3] = '{1'b0, 8'h01, 4'd0,  0, 1'b0, 1'b0, -1, 2'b10, 1'b0, 17'h10008, 1'b1};
    tbl[4] = '{1'b1, 8'h02, 4'd1,  2, 1'b0, 1'b0,  1, 2'b00, 1'b0, 17'h10010, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 4'd15, 0, 1'b0, 1'b0, -1, 2'b00, 1'b1, 17'h10000, 1'b0};
    tbl[6] = '{1'b1, 8'h80, 4'd15, 0, 1'b1, 1'b0, -1, 2'b00, 1'b0, 17'h10400, 1'b0};

    rdata_nz = 0;
    cfg = tbl[0];
    clear_state();
    repeat (3) @(negedge clk);
    chk("reset_flags", {56'd0, C_busy, C_out_valid, C_wready, C_rvalid, C_err,
        bus.AR_VALID, bus.AW_VALID, bus.W_VALID}, 64'd0);
    chk("reset_ready", {62'd0, bus.R_READY, bus.B_READY}, 64'd0);
    chk("reset_ar_addr", 64'(bus.AR_ADDR), 64'd0);
    chk("reset_aw_addr", 64'(bus.AW_ADDR), 64'd0);
    chk("reset_w_data", bus.W_DATA, 64'd0);
    chk("reset_rdata", C_rdata, 64'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", 64'(C_busy), 64'd0);

    for (int k = 0; k < 7; k++) run_vec(tbl[k], $sformatf("v%0d", k));

    // Reset in the middle of a 4-beat read, then a normal read.
    v = '{1'b1, 8'h03, 4'd3, 0, 1'b0, 1'b0, -1, 2'b00, 1'b0, 17'h10018, 1'b0};
    start_req(v);
    n = 0;
    while (rd_q.size() < 1 && n < 50) begin
      tick(); n++;
    end
    chk("rst_mid_one_beat", 64'(rd_q.size()), 64'd1);
    rst = 1;
    #1;
    chk("rst_mid_flags", {55'd0, C_busy, C_out_valid, C_wready, C_rvalid, C_err,
        bus.AR_VALID, bus.R_READY, bus.AW_VALID, bus.W_VALID}, 64'd0);
    chk("rst_mid_rdata", C_rdata, 64'd0);
    @(negedge clk);
    chk("rst_mid_no_done", 64'(C_out_valid), 64'd0);
    clear_state();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_vec(tbl[0], "post_rst");

`ifdef AXI_BRIDGE_TIMEOUT_EN
    // AR_READY never comes: the watchdog must end the transaction with an error.
    v = '{1'b1, 8'h07, 4'd0, 100000, 1'b0, 1'b0, -1, 2'b00, 1'b0, 17'h10038, 1'b1};
    start_req(v);
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      tick(); n++;
    end
    chk("to_arvalid_cycles", 64'(arv_cycles), 64'd16);
    chk("to_done", 64'(done_cnt), 64'd1);
    chk("to_err", 64'(done_err), 64'd1);
    chk("to_no_ar_hs", 64'(ar_hs), 64'd0);
    tick();
    chk("to_idle", 64'(C_busy), 64'd0);
`endif

    chk("rdata_zero_when_not_valid", 64'(rdata_nz), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
